// File: rtl/dma_w_burst_ctrl_pkg.sv
// Shared constants, AXI widths and FSM state encoding for the DMA write burst controller.
package dma_w_burst_ctrl_pkg;

    localparam int AXI_ADDR_W    = 32;
    localparam int AXI_LEN_W     = 8;
    localparam int DMA_BOUNDARY  = 4096;
    localparam int DMA_MAX_BURST = 256;
    // Wide enough to hold DMA_MAX_BURST itself.
    localparam int BEATS_W       = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DATA  = 3'd3,
        ST_WAIT  = 3'd4
    } dma_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: beats = min(remaining, max burst, beats left before the next 4 KB page).
module dma_burst_calc
    import dma_w_burst_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int BYTES = 4
) (
    input  logic [11:0]        cur_addr,
    input  logic [CNT_W-1:0]   remaining,
    output logic [BEATS_W-1:0] beats
);

    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int CMP_W = (CNT_W > 13) ? CNT_W : 13;

    logic [11:0]      page_off;
    logic [12:0]      room_beats;
    logic [12:0]      lim;
    logic [CMP_W-1:0] rem_x;
    logic [CMP_W-1:0] lim_x;

    always_comb begin
        page_off   = cur_addr & ~12'(BYTES - 1);
        room_beats = (13'(DMA_BOUNDARY) - {1'b0, page_off}) >> OFF_W;
        lim        = (room_beats > 13'(DMA_MAX_BURST)) ? 13'(DMA_MAX_BURST) : room_beats;
        rem_x      = CMP_W'(remaining);
        lim_x      = CMP_W'(lim);
        // When remaining is the smaller term it is below 257, so its low bits are exact.
        if (rem_x < lim_x) begin
            beats = remaining[BEATS_W-1:0];
        end else begin
            beats = lim[BEATS_W-1:0];
        end
    end

endmodule

// File: rtl/dma_w_burst_ctrl.sv
// DMA write burst controller: splits a word-count transfer into page-safe bursts of up to 256 beats.
// Handshake: a transfer moves on a cycle where valid and ready are both high; valid never waits on ready.
module dma_w_burst_ctrl
    import dma_w_burst_ctrl_pkg::*;
#(
    parameter  int ADDR_W     = AXI_ADDR_W,
    parameter  int DMA_DATA_W = 32,
    parameter  int CNT_W      = 32,
    localparam int BYTES      = DMA_DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [CNT_W-1:0]      word_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DMA_DATA_W-1:0] s_data,
    output logic                  valid,
    input  logic                  ready,
    output logic [ADDR_W-1:0]     addr,
    output logic [DMA_DATA_W-1:0] wdata,
    output logic [BYTES-1:0]      wstrb,
    output logic [AXI_LEN_W-1:0]  dma_len,
    input  logic                  dma_ready,
    input  logic                  dma_error,
    output dma_state_e            state_dbg
);

    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;

    dma_state_e         state, state_nxt;
    logic [ADDR_W-1:0]  cur_addr;
    logic [CNT_W-1:0]   remaining;
    logic [BEATS_W-1:0] beats_r;
    logic [BEATS_W-1:0] beat_cnt;
    logic [BEATS_W-1:0] calc_beats;
    logic               beat_fire;
    logic               last_beat;

    dma_burst_calc #(
        .CNT_W (CNT_W),
        .BYTES (BYTES)
    ) u_calc (
        .cur_addr  (cur_addr[11:0]),
        .remaining (remaining),
        .beats     (calc_beats)
    );

    assign beat_fire = (state == ST_DATA) && s_valid && ready;
    assign last_beat = beat_fire && (beat_cnt == beats_r - 9'd1);
    assign busy      = (state != ST_IDLE);
    assign wdata     = s_data;
    assign wstrb     = '1;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        s_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                state_nxt = (remaining == '0) ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                valid = dma_ready;
                if (dma_ready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                valid   = s_valid;
                s_ready = ready;
                if (last_beat) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (dma_ready) state_nxt = ST_CALC;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            beats_r   <= '0;
            beat_cnt  <= '0;
            addr      <= '0;
            dma_len   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr  <= start_addr & ~ADDR_W'(BYTES - 1);
                        remaining <= word_cnt;
                        error     <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (remaining == '0) begin
                        done <= 1'b1;
                    end else begin
                        beats_r <= calc_beats;
                        dma_len <= AXI_LEN_W'(calc_beats - 9'd1);
                        addr    <= cur_addr;
                    end
                end
                ST_ISSUE: begin
                    beat_cnt <= '0;
                end
                ST_DATA: begin
                    if (beat_fire) beat_cnt <= beat_cnt + 9'd1;
                    if (last_beat) begin
                        remaining <= remaining - CNT_W'(beats_r);
                        cur_addr  <= cur_addr + (ADDR_W'(beats_r) << OFF_W);
                    end
                end
                ST_WAIT: begin
                    if (dma_ready) error <= error | dma_error;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_w_burst_ctrl.sv
// Bench for dma_w_burst_ctrl: random upstream/downstream timing against a burst-plan reference model.
module tb_dma_w_burst_ctrl;
    import dma_w_burst_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [31:0] word_cnt = '0;
    logic        busy, done, error;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  dma_len;
    logic        dma_ready = 1'b1;
    logic        dma_error = 1'b0;
    dma_state_e  state_dbg;

    dma_w_burst_ctrl #(.ADDR_W(32), .DMA_DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .error(error),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .valid(valid), .ready(ready), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .dma_len(dma_len), .dma_ready(dma_ready), .dma_error(dma_error), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];
    logic [31:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    logic        bq_err[$];
    int          ws_phase = 0;
    int          beats_left = 0;
    int          resp_wait = 0;
    logic        cur_err = 1'b0;
    logic        dma_err_r = 1'b0;
    logic [31:0] cur_baddr = '0;
    logic [7:0]  cur_blen = '0;
    int          gap_pct = 0;
    int          done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Plans the bursts from the addressing rules and returns the expected sticky error.
    task automatic plan(input logic [31:0] a, input int unsigned n, input logic [31:0] err_bits,
                        output logic exp_err);
        int unsigned room, b, k;
        logic [31:0] cur;
        cur = a & 32'hFFFF_FFFC;
        k = 0;
        exp_err = 1'b0;
        while (n > 0) begin
            room = (4096 - (cur % 4096)) / 4;
            b = n;
            if (b > 256) b = 256;
            if (b > room) b = room;
            bq_addr.push_back(cur);
            bq_len.push_back(8'(b - 1));
            bq_err.push_back(err_bits[k % 32]);
            exp_err = exp_err | err_bits[k % 32];
            cur = cur + b * 4;
            n = n - b;
            k++;
        end
    endtask

    // Write-stage model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (ws_phase != 1) chk("s_ready_outside_data", s_ready, 1'b0);
            case (ws_phase)
                0: begin
                    if (valid) begin
                        if (bq_addr.size() == 0) begin
                            chk("unexpected_valid", valid, 1'b0);
                        end else begin
                            cur_baddr = bq_addr.pop_front();
                            cur_blen  = bq_len.pop_front();
                            cur_err   = bq_err.pop_front();
                            chk("burst_addr", addr, cur_baddr);
                            chk("burst_len", dma_len, cur_blen);
                            chk("wstrb", wstrb, 4'hF);
                            beats_left = int'(cur_blen) + 1;
                            ws_phase = 1;
                        end
                    end
                end
                1: begin
                    chk("addr_stable", addr, cur_baddr);
                    chk("len_stable", dma_len, cur_blen);
                    chk("s_ready_follows_ready", s_ready, ready);
                    if (valid && ready) begin
                        if (exp_q.size() == 0) chk("extra_beat", valid, 1'b0);
                        else chk("wdata", wdata, exp_q.pop_front());
                        beats_left--;
                        if (beats_left == 0) begin
                            ws_phase = 2;
                            resp_wait = $urandom_range(0, 3);
                        end
                    end
                end
                default: begin
                    chk("valid_after_last_beat", valid, 1'b0);
                    if (resp_wait == 0) begin
                        ws_phase = 0;
                        dma_err_r = cur_err;
                    end else begin
                        resp_wait--;
                    end
                end
            endcase
            if (s_valid && s_ready && src_q.size() > 0) void'(src_q.pop_front());
        end
    end

    // Upstream source and write-stage response drivers.
    always @(posedge clk) begin
        #1;
        dma_ready = (ws_phase == 0);
        dma_error = (ws_phase == 0) ? dma_err_r : 1'($urandom_range(0, 1));
        ready = ($urandom_range(0, 99) < 80);
        if (src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
        end
    end

    task automatic load(input logic [31:0] a, input int unsigned n, input logic [31:0] err_bits,
                        output logic exp_err);
        logic [31:0] d;
        plan(a, n, err_bits, exp_err);
        for (int i = 0; i < int'(n); i++) begin
            d = $urandom;
            src_q.push_back(d);
            exp_q.push_back(d);
        end
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; word_cnt = n;
        @(posedge clk); #1;
        start = 1'b0; start_addr = $urandom; word_cnt = $urandom;
    endtask

    task automatic run_xfer(input logic [31:0] a, input int unsigned n, input logic [31:0] err_bits,
                            input bit poke);
        logic exp_err;
        int   cyc;
        bit   seen;
        load(a, n, err_bits, exp_err);
        @(negedge clk);
        chk("busy_after_start", busy, 1'b1);
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 20 && busy) begin
                start = 1'b1; start_addr = 32'h0000_8000; word_cnt = 5;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("done_seen", seen, 1'b1);
        if (n == 0) chk("zero_cnt_done_latency", cyc, 1);
        chk("error_at_done", error, exp_err);
        chk("bursts_left", bq_addr.size(), 0);
        chk("data_left", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_err;
        int   d0, cyc;
        bit   reached;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_len", dma_len, 8'h0);
        chk("rst_state", state_dbg, ST_IDLE);

        // Directed transfers with a steady upstream.
        gap_pct = 0;
        run_xfer(32'h0000_1000, 4, 32'h0, 0);
        run_xfer(32'h0000_0FF8, 6, 32'h0, 0);
        run_xfer(32'h0000_0000, 300, 32'h0, 1);
        run_xfer(32'h0000_0040, 0, 32'h0, 0);
        run_xfer(32'h0000_0FF8, 6, 32'h1, 0);
        run_xfer(32'h0000_2003, 3, 32'h0, 0);

        // Random transfers with upstream bubbles.
        gap_pct = 40;
        for (int t = 0; t < 5; t++) begin
            run_xfer({$urandom_range(0, 15), 12'h000} + 32'($urandom_range(0, 1023) * 4),
                     $urandom_range(1, 400), $urandom, 0);
        end
        run_xfer(32'hFFFF_FFF0, 8, 32'h0, 0);

        // Reset in the middle of the second burst, after the first one reported an error.
        load(32'h0000_0FF0, 600, 32'h1, exp_err);
        reached = 0;
        cyc = 0;
        while (!reached && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (error && ws_phase == 1 && beats_left < 200) reached = 1;
        end
        chk("reach_mid_data", reached, 1'b1);
        d0 = done_cnt;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_error", error, 1'b0);
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_s_ready", s_ready, 1'b0);
        chk("mid_rst_addr", addr, 32'h0);
        chk("mid_rst_len", dma_len, 8'h0);
        chk("mid_rst_state", state_dbg, ST_IDLE);
        exp_q.delete(); src_q.delete();
        bq_addr.delete(); bq_len.delete(); bq_err.delete();
        ws_phase = 0; dma_err_r = 1'b0; beats_left = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", done_cnt, d0);
        chk("idle_after_rst", busy, 1'b0);

        gap_pct = 20;
        run_xfer(32'h0000_3FF0, 10, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
